// File: rtl/piso_tx8.sv
// Parallel-in/serial-out frame transmitter: LSB first, one bit per tick, then a one-cycle done pulse.
// A start is accepted only in IDLE (ready=1); with tick held high, frames can be accepted every WIDTH+2 cycles.
module piso_tx8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] PI,
  input  logic             tick,
  output logic             serOut,
  output logic             sValid,
  output logic             ready,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs decode only registered state, so start/tick never reach them combinationally.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    sValid    = 1'b0;
    done      = 1'b0;
    serOut    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          sreg_nxt  = PI;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sValid = 1'b1;
        serOut = sreg[0];
        if (tick) begin
          sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx8.sv
// Bench for piso_tx8: queue-based frame model compared every cycle, a loopback receiver,
// directed scenarios with literal expectations, then a randomized soak.
module tb_piso_tx8;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] PI;
  logic         tick;
  logic         serOut;
  logic         sValid;
  logic         ready;
  logic         done;

  piso_tx8 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .PI     (PI),
    .tick   (tick),
    .serOut (serOut),
    .sValid (sValid),
    .ready  (ready),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;

  // Model: the bits still to be sent, plus a pending done pulse.
  bit         mq[$];
  bit         m_done = 1'b0;
  logic [7:0] m_word = '0;

  // Observations of the DUT.
  logic [7:0] seq = '0;
  logic [7:0] rx = '0;
  logic [7:0] rx_last = '0;
  int         nbits = 0;
  int         vcyc = 0;
  int         done_cnt = 0;
  int         acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit ev;
    @(negedge clk);
    if (chk_en) begin
      ev = (mq.size() != 0);
      chk("sValid", 32'(sValid), 32'(ev));
      chk("serOut", 32'(serOut), 32'(ev ? mq[0] : 1'b0));
      chk("done", 32'(done), 32'(m_done));
      chk("ready", 32'(ready), 32'(!ev && !m_done));
      if (m_done) chk("loopback_word", 32'(rx), 32'(m_word));
      if (ready && start && !rst) begin
        acc_q.push_back(cyc);
        seq   = '0;
        nbits = 0;
        vcyc  = 0;
      end
      if (sValid === 1'b1) vcyc++;
      if (sValid === 1'b1 && tick) begin
        seq = {seq[6:0], serOut};
        rx  = {serOut, rx[7:1]};
        nbits++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        rx_last = rx;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (tick) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      m_word = PI;
      for (int i = 0; i < W; i++) mq.push_back(PI[i]);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    PI    = w;
    start = 1'b1;
    step();
    start = 1'b0;
    PI    = 8'($urandom);
  endtask

  // mode 0: tick held high; mode 1: tick on every third cycle after the accept.
  task automatic wait_done(input int mode, input string name);
    int  d0;
    int  k;
    bit  seen;
    d0   = done_cnt;
    k    = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick = (mode == 0) ? 1'b1 : ((k % 3) == 2);
      step();
      k++;
      if (done_cnt > d0) begin
        seen = 1'b1;
        break;
      end
    end
    tick = 1'b1;
    if (!seen) chk({name, "_timeout"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  logic [7:0] lb_words[3];
  int         d0;
  int         a0;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    PI    = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_sValid", 32'(sValid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_serOut", 32'(serOut), 32'd0);

    // Basic frame
    tick = 1'b1;
    d0 = done_cnt;
    send(8'hA5);
    wait_done(0, "basic");
    chk("basic_seq", 32'(seq), 32'(8'b10100101));
    chk("basic_bits", 32'(nbits), 32'd8);
    chk("basic_valid_cycles", 32'(vcyc), 32'd8);
    chk("basic_ready_after", 32'(ready), 32'd1);
    chk("basic_done_count", 32'(done_cnt - d0), 32'd1);

    // Loopback
    lb_words[0] = 8'h3C;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      send(lb_words[i]);
      wait_done(0, "loopback");
      chk("loopback_rx", 32'(rx_last), 32'(lb_words[i]));
    end

    // Tick gating
    send(8'h81);
    wait_done(1, "gate");
    chk("gate_seq", 32'(seq), 32'(8'b10000001));
    chk("gate_valid_cycles", 32'(vcyc), 32'd24);
    chk("gate_rx", 32'(rx_last), 32'h81);

    // Start while busy: during bit 3 and during DONE
    d0 = done_cnt;
    a0 = acc_q.size();
    send(8'h0F);
    repeat (3) step();
    PI    = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("busy_done_state", 32'(done), 32'd1);
    PI    = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_seq", 32'(seq), 32'(8'b11110000));
    chk("busy_rx", 32'(rx_last), 32'h0F);
    chk("busy_accepts", 32'(acc_q.size() - a0), 32'd1);
    repeat (12) step();
    chk("busy_done_count", 32'(done_cnt - d0), 32'd1);
    chk("busy_ready_idle", 32'(ready), 32'd1);

    // Reset mid-frame, after bit 4
    d0 = done_cnt;
    send(8'hC3);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_serOut", 32'(serOut), 32'd0);
    chk("abort_sValid", 32'(sValid), 32'd0);
    repeat (3) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h5A);
    wait_done(0, "after_abort");
    chk("after_abort_seq", 32'(seq), 32'(8'b01011010));
    chk("after_abort_rx", 32'(rx_last), 32'h5A);

    // Back-to-back with start held high
    a0 = acc_q.size();
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      PI = (i % 2 == 1) ? 8'h80 : 8'h01;
      step();
    end
    start = 1'b0;
    repeat (12) step();
    chk("b2b_accepts", 32'(acc_q.size() - a0), 32'd5);
    for (int i = a0 + 1; i < acc_q.size(); i++)
      chk("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd10);

    // Randomized soak
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      PI    = 8'($urandom);
      tick  = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 149) == 0);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    tick  = 1'b1;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx8.md
PISO_TX8 -- requirements
Module: piso_tx8

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits; SHALL be >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  load request; accepted only when ready=1.
REQ-005 PI  input  WIDTH  parallel word, sampled on the accepting edge only.
REQ-006 tick  input  1  bit-advance strobe; the serial stream advances one bit per edge with tick=1.
REQ-007 serOut  output  1  serial data, LSB first, feeding the team's serial-in/parallel-out receiver.
REQ-008 sValid  output  1  high while serOut carries a frame bit.
REQ-009 ready  output  1  high when a new start will be accepted.
REQ-010 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE, registered, with no other reachable state.
REQ-012 IDLE: ready=1, sValid=0, done=0, serOut=0.
REQ-013 IDLE with start=1 at an edge: shift register <= PI, bit counter <= 0, next state SHIFT.
REQ-014 SHIFT: ready=0, sValid=1, serOut = shift register bit 0 (combinational from the register).
REQ-015 SHIFT, edge with tick=1: shift register shifts right with 0 fill, counter +1.
REQ-016 SHIFT, edge with tick=0: register, counter and state hold, so serOut is stable.
REQ-017 SHIFT, edge with tick=1 and counter=WIDTH-1: next state DONE; counter wraps to 0.
REQ-018 DONE lasts exactly one cycle: done=1, ready=0, sValid=0, serOut=0; next state IDLE unconditionally.
REQ-019 start in SHIFT or DONE SHALL be ignored and SHALL NOT alter PI capture, counter or state.
REQ-020 tick in IDLE or DONE SHALL have no effect.
REQ-021 Counter width SHALL be ceil(log2(WIDTH)) bits, and compares SHALL be done at that width.
REQ-022 Latency with tick held 1: start accepted at edge k; bit i on serOut during cycle k+1+i (i=0..WIDTH-1); done during cycle k+WIDTH+1; ready during cycle k+WIDTH+2.
REQ-023 Minimum spacing between accepted starts SHALL be WIDTH+2 cycles.
REQ-024 Bit order: a receiver that shifts serial input into its MSB and shifts right on each edge with sValid=1 SHALL hold PI exactly after WIDTH such edges.
REQ-025 All outputs SHALL be glitch-free functions of registered state, with no zero-delay combinational path from start or tick to any output.

Reset
REQ-026 rst=1 at an edge: state <= IDLE, shift register <= 0, counter <= 0, which gives ready=1, sValid=0, done=0, serOut=0 in the next cycle.
REQ-027 rst SHALL take priority over start and tick at the same edge.
REQ-028 rst mid-frame SHALL abort the frame with no done pulse; the partial frame is discarded.
REQ-029 After rst is released, the first start SHALL be accepted normally.

Verification
REQ-030 Basic frame:
- Stimulus: rst 2 cycles, tick=1, start=1 for one cycle with PI=8'hA5.
- Response: serOut 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sValid=1, then done=1 for one cycle, then ready=1.
REQ-031 Loopback:
- Stimulus: serOut and sValid wired into an 8-bit serial-in/parallel-out register with shift enable; send 8'h3C, then 8'hFF, then 8'h00.
- Response: the receiver's parallel output equals each word on the done cycle.
REQ-032 Tick gating:
- Stimulus: PI=8'h81, tick=1 every 3rd cycle.
- Response: each bit held exactly 3 cycles; done 24 cycles after the first bit appears; sequence 1,0,0,0,0,0,0,1.
REQ-033 Start while busy:
- Stimulus: start with PI=8'h0F, then start with PI=8'hF0 during bit 3, then again during DONE.
- Response: serOut sends only 1,1,1,1,0,0,0,0; exactly one done pulse.
REQ-034 Reset mid-frame:
- Stimulus: PI=8'hC3, rst=1 for one cycle after bit 4.
- Response: no done pulse; next cycle ready=1, serOut=0; a following start with PI=8'h5A transmits 0,1,0,1,1,0,1,0.
REQ-035 Back-to-back:
- Stimulus: start held high continuously, PI toggling between 8'h01 and 8'h80 each cycle.
- Response: accepts spaced exactly 10 cycles apart; each frame carries the PI value present on its accepting edge.
